// File: rtl/alu_pkg.sv
// Shared definitions for the MIPS execute stage: ALU control encodings,
// buffer states and the EX/MEM entry layout.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_REG_W  = 5;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1110;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    logic                  zero;
    logic [ALU_REG_W-1:0]  dst_reg;
    logic                  reg_write;
    logic                  bad_op;
    logic                  ovf;
  } ex_entry;

  function automatic ex_entry resetEntry();
    ex_entry e;
    e.result    = '0;
    e.zero      = 1'b1;
    e.dst_reg   = '0;
    e.reg_write = 1'b0;
    e.bad_op    = 1'b0;
    e.ovf       = 1'b0;
    return e;
  endfunction

endpackage

// File: rtl/alu_ex_stage_core.sv
// Combinational MIPS ALU: evaluates one ALU control encoding on two operands
// and flags unsupported encodings and signed ADD/SUB overflow.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic               [3:0]        opCode,
  input  logic signed        [DATA_W-1:0] opA,
  input  logic signed        [DATA_W-1:0] opB,
  input  logic               [4:0]        shamt,
  output logic               [DATA_W-1:0] result,
  output logic                            zero,
  output logic                            badOp,
  output logic                            ovf
);

  logic signed [DATA_W-1:0] sum;
  logic signed [DATA_W-1:0] diff;
  logic                     lessThan;

  assign sum      = opA + opB;
  assign diff     = opA - opB;
  assign lessThan = (opA < opB);

  always_comb begin
    result = '0;
    badOp  = 1'b0;
    ovf    = 1'b0;
    unique case (opCode)
      OP_AND: result = opA & opB;
      OP_OR:  result = opA | opB;
      OP_ADD: begin
        result = sum;
        // Operands of equal sign producing a result of the other sign.
        ovf    = (opA[DATA_W-1] == opB[DATA_W-1]) && (sum[DATA_W-1] != opA[DATA_W-1]);
      end
      OP_SUB: begin
        result = diff;
        ovf    = (opA[DATA_W-1] != opB[DATA_W-1]) && (diff[DATA_W-1] != opA[DATA_W-1]);
      end
      OP_SLT: result = {{(DATA_W-1){1'b0}}, lessThan};
      OP_NOR: result = ~(opA | opB);
      OP_SLL: result = opB << shamt;
      default: badOp = 1'b1;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_ex_stage.sv
// MIPS execute stage: ALU plus a two-entry (main + skid) EX/MEM buffer with
// registered in_ready. Define ALU_OVF_TRAP_EN to add the ovf trap output.
module alu_ex_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int REG_W  = ALU_REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_code,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [4:0]        shamt,
  input  logic [REG_W-1:0]  dst_reg,
  input  logic              reg_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic [REG_W-1:0]  out_dst_reg,
  output logic              out_reg_write,
`ifdef ALU_OVF_TRAP_EN
  output logic              ovf,
`endif
  output logic              bad_op
);

  buf_state_e  state_p1, stateNext;
  logic        inReady_p1;
  ex_entry     mainEntry_p1, skidEntry_p1, newEntry;
  logic        inXfer, outXfer;
  logic        loadMain, loadSkid, skidToMain;

  logic [DATA_W-1:0] coreResult;
  logic              coreZero, coreBad, coreOvf;

  alu_core #(.DATA_W(DATA_W)) uCore (
    .opCode (op_code),
    .opA    (op_a),
    .opB    (op_b),
    .shamt  (shamt),
    .result (coreResult),
    .zero   (coreZero),
    .badOp  (coreBad),
    .ovf    (coreOvf)
  );

  always_comb begin
    newEntry.result  = coreResult;
    newEntry.zero    = coreZero;
    newEntry.dst_reg = dst_reg;
    newEntry.bad_op  = coreBad;
    newEntry.ovf     = coreOvf;
`ifdef ALU_OVF_TRAP_EN
    newEntry.reg_write = reg_write && !coreBad && !coreOvf;
`else
    newEntry.reg_write = reg_write && !coreBad;
`endif
  end

  // Flush kills anything presented in the same cycle as well as held entries.
  assign inXfer  = in_valid && inReady_p1 && !flush;
  assign outXfer = (state_p1 != ST_EMPTY) && out_ready;

  always_comb begin
    stateNext  = state_p1;
    loadMain   = 1'b0;
    loadSkid   = 1'b0;
    skidToMain = 1'b0;
    if (flush) begin
      stateNext = ST_EMPTY;
    end else begin
      unique case (state_p1)
        ST_EMPTY: if (inXfer) begin
          stateNext = ST_ONE;
          loadMain  = 1'b1;
        end
        ST_ONE: begin
          if (inXfer && outXfer) begin
            loadMain = 1'b1;
          end else if (inXfer) begin
            stateNext = ST_FULL;
            loadSkid  = 1'b1;
          end else if (outXfer) begin
            stateNext = ST_EMPTY;
          end
        end
        ST_FULL: if (outXfer) begin
          stateNext  = ST_ONE;
          skidToMain = 1'b1;
        end
        default: stateNext = ST_EMPTY;
      endcase
    end
  end

  // EX/MEM register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1   <= ST_EMPTY;
      inReady_p1 <= 1'b1;
    end else begin
      state_p1   <= stateNext;
      inReady_p1 <= (stateNext != ST_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mainEntry_p1 <= resetEntry();
      skidEntry_p1 <= resetEntry();
    end else begin
      if (loadMain)        mainEntry_p1 <= newEntry;
      else if (skidToMain) mainEntry_p1 <= skidEntry_p1;
      if (loadSkid)        skidEntry_p1 <= newEntry;
    end
  end

  assign in_ready      = inReady_p1;
  assign out_valid     = (state_p1 != ST_EMPTY);
  assign result        = mainEntry_p1.result;
  assign zero          = mainEntry_p1.zero;
  assign out_dst_reg   = mainEntry_p1.dst_reg;
  assign out_reg_write = mainEntry_p1.reg_write;
  assign bad_op        = mainEntry_p1.bad_op;

`ifdef ALU_OVF_TRAP_EN
  assign ovf = mainEntry_p1.ovf;
`else
  logic unusedOvf;
  assign unusedOvf = mainEntry_p1.ovf;
`endif

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage: ALU results, skid-buffer backpressure,
// flush and asynchronous reset, plus the overflow trap when it is built in.
module tb_alu_ex_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op_code = 4'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  shamt = '0;
  logic [4:0]  dst_reg = '0;
  logic        reg_write = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic [4:0]  out_dst_reg;
  logic        out_reg_write;
  logic        bad_op;
`ifdef ALU_OVF_TRAP_EN
  logic        ovf;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_code(op_code), .op_a(op_a), .op_b(op_b), .shamt(shamt),
    .dst_reg(dst_reg), .reg_write(reg_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .out_dst_reg(out_dst_reg),
    .out_reg_write(out_reg_write),
`ifdef ALU_OVF_TRAP_EN
    .ovf(ovf),
`endif
    .bad_op(bad_op)
  );

  task automatic setOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [4:0] dst, input logic rw);
    op_code = op; op_a = a; op_b = b; shamt = sh; dst_reg = dst; reg_write = rw;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present one op for a single accepting edge; returns at posedge+1.
  task automatic doOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh, input logic [4:0] dst, input logic rw);
    int n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL doop_ready_timeout got in_ready=%b expected 1", in_ready);
    end
    setOp(op, a, b, sh, dst, rw);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got %h expected 0", result); end
    checks++; if (zero !== 1'b1) begin failures++; $display("FAIL reset_zero got %b expected 1", zero); end
    checks++; if (out_dst_reg !== 5'd0) begin failures++; $display("FAIL reset_dst got %0d expected 0", out_dst_reg); end
    checks++; if (out_reg_write !== 1'b0) begin failures++; $display("FAIL reset_reg_write got %b expected 0", out_reg_write); end
    checks++; if (bad_op !== 1'b0) begin failures++; $display("FAIL reset_bad_op got %b expected 0", bad_op); end
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    doOp(OP_ADD, 32'h5, 32'h3, 5'd0, 5'd4, 1'b1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got %b expected 1", out_valid); end
    checks++; if (result !== 32'h8) begin failures++; $display("FAIL add_result got %h expected 00000008", result); end
    checks++; if (zero !== 1'b0) begin failures++; $display("FAIL add_zero got %b expected 0", zero); end
    checks++; if (out_dst_reg !== 5'd4) begin failures++; $display("FAIL add_dst got %0d expected 4", out_dst_reg); end
    checks++; if (out_reg_write !== 1'b1) begin failures++; $display("FAIL add_reg_write got %b expected 1", out_reg_write); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_drain got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_sub_slt();
    doOp(OP_SUB, 32'h7, 32'h7, 5'd0, 5'd2, 1'b1);
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL sub_result got %h expected 0", result); end
    checks++; if (zero !== 1'b1) begin failures++; $display("FAIL sub_zero got %b expected 1", zero); end
    doOp(OP_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0, 5'd3, 1'b1);
    checks++; if (result !== 32'h1) begin failures++; $display("FAIL slt_neg_result got %h expected 00000001", result); end
    doOp(OP_SLT, 32'h1, 32'hFFFF_FFFF, 5'd0, 5'd3, 1'b1);
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL slt_pos_result got %h expected 0", result); end
    tick();
  endtask

  task automatic test_sll_nor_bad();
    doOp(OP_SLL, 32'hDEAD_BEEF, 32'h1, 5'd31, 5'd5, 1'b1);
    checks++; if (result !== 32'h8000_0000) begin failures++; $display("FAIL sll_result got %h expected 80000000", result); end
    doOp(OP_NOR, 32'h0, 32'h0, 5'd0, 5'd6, 1'b1);
    checks++; if (result !== 32'hFFFF_FFFF) begin failures++; $display("FAIL nor_result got %h expected ffffffff", result); end
    doOp(4'b1010, 32'h12, 32'h34, 5'd0, 5'd7, 1'b1);
    checks++; if (bad_op !== 1'b1) begin failures++; $display("FAIL bad_flag got %b expected 1", bad_op); end
    checks++; if (out_reg_write !== 1'b0) begin failures++; $display("FAIL bad_reg_write got %b expected 0", out_reg_write); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL bad_result got %h expected 0", result); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    setOp(OP_ADD, 32'h10, 32'h1, 5'd0, 5'd1, 1'b1);
    in_valid = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got %b expected 1", in_ready); end
    checks++; if (result !== 32'h11) begin failures++; $display("FAIL bp_first got %h expected 00000011", result); end
    setOp(OP_SUB, 32'h20, 32'h8, 5'd0, 5'd2, 1'b1);
    tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full got %b expected 0", in_ready); end
    setOp(OP_OR, 32'hF0, 32'h0F, 5'd0, 5'd3, 1'b1);
    tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_held got %b expected 0", in_ready); end
    checks++; if (result !== 32'h11 || out_dst_reg !== 5'd1) begin failures++; $display("FAIL bp_stable got %h/%0d expected 00000011/1", result, out_dst_reg); end
    out_ready = 1'b1;
    tick();
    checks++; if (result !== 32'h18 || out_dst_reg !== 5'd2) begin failures++; $display("FAIL bp_second got %h/%0d expected 00000018/2", result, out_dst_reg); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_reopen got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (result !== 32'hFF || out_dst_reg !== 5'd3 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_third got %h/%0d/%b expected 000000ff/3/1", result, out_dst_reg, out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got %b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    setOp(OP_ADD, 32'h1, 32'h1, 5'd0, 5'd8, 1'b1);
    in_valid = 1'b1;
    tick();
    setOp(OP_ADD, 32'h2, 32'h2, 5'd0, 5'd9, 1'b1);
    tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_prefull got in_ready=%b expected 0", in_ready); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_full_valid got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_full_ready got %b expected 1", in_ready); end
    setOp(OP_OR, 32'h3, 32'h0, 5'd0, 5'd10, 1'b1);
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_discard got out_valid=%b expected 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_discard_late got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    doOp(OP_ADD, 32'h5, 32'h3, 5'd0, 5'd7, 1'b1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL areset_pre got out_valid=%b expected 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL areset_ctrl got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
    checks++; if (result !== 32'h0 || zero !== 1'b1 || out_reg_write !== 1'b0 || out_dst_reg !== 5'd0) begin failures++; $display("FAIL areset_data got %h/%b/%b/%0d expected 0/1/0/0", result, zero, out_reg_write, out_dst_reg); end
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL areset_after got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    doOp(OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 5'd11, 1'b1);
    checks++; if (result !== 32'h8000_0000) begin failures++; $display("FAIL ovf_add_result got %h expected 80000000", result); end
`ifdef ALU_OVF_TRAP_EN
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_add_flag got %b expected 1", ovf); end
    checks++; if (out_reg_write !== 1'b0) begin failures++; $display("FAIL ovf_add_reg_write got %b expected 0", out_reg_write); end
    doOp(OP_SUB, 32'h8000_0000, 32'h1, 5'd0, 5'd12, 1'b1);
    checks++; if (result !== 32'h7FFF_FFFF || ovf !== 1'b1) begin failures++; $display("FAIL ovf_sub got %h/%b expected 7fffffff/1", result, ovf); end
    doOp(OP_ADD, 32'h1, 32'h1, 5'd0, 5'd13, 1'b1);
    checks++; if (ovf !== 1'b0 || out_reg_write !== 1'b1) begin failures++; $display("FAIL ovf_clear got %b/%b expected 0/1", ovf, out_reg_write); end
`else
    checks++; if (out_reg_write !== 1'b1) begin failures++; $display("FAIL wrap_reg_write got %b expected 1", out_reg_write); end
`endif
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_sll_nor_bad();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_ex_stage.md
Name: alu_ex_stage

Overview:
- Execute stage of the pipelined MIPS core. Sits directly downstream of the ALU control unit.
- Consumes the 4-bit ALU operation code plus operands from the ID/EX side, evaluates the ALU operation, and holds results in a registered EX/MEM output.
- Uses valid/ready handshakes on both sides and a 2-entry skid buffer, so in_ready is a registered signal and downstream stalls never drop data.

Parameters:
- DATA_W, 32, operand/result width.
- REG_W, 5, destination register index width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous kill of all held entries (branch mispredict).
- in_valid  input  1  upstream has a valid operation.
- in_ready  output  1  stage can accept this cycle (registered).
- op_code  input  4  ALU control encoding: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1110 SLL.
- op_a  input  DATA_W  rs operand.
- op_b  input  DATA_W  rt operand or sign-extended immediate.
- shamt  input  5  shift amount for SLL.
- dst_reg  input  REG_W  writeback register index.
- reg_write  input  1  writeback enable.
- out_valid  output  1  EX/MEM entry valid.
- out_ready  input  1  MEM stage accepts.
- result  output  DATA_W  ALU result.
- zero  output  1  result == 0.
- out_dst_reg  output  REG_W  forwarded dst_reg.
- out_reg_write  output  1  forwarded reg_write, possibly suppressed.
- bad_op  output  1  op_code not in the supported set.

Behaviour:
- Reset (async, rst_n low): out_valid=0, in_ready=1, result=0, zero=1, out_dst_reg=0, out_reg_write=0, bad_op=0. Both buffer entries are invalid.
- Transfers: an input transfer occurs when in_valid&&in_ready; an output transfer occurs when out_valid&&out_ready.
- Latency: an op accepted in cycle N is presented with out_valid=1 in cycle N+1 if the output register was empty or draining.
- Arithmetic: ADD/SUB are modulo 2^DATA_W. SLT is a signed compare and gives 1 or 0 zero-extended. SLL gives op_b << shamt (op_a ignored). NOR is ~(a|b).
- Unsupported op_code: result=0, bad_op=1, out_reg_write=0.
- Buffering: main register plus skid register.
  - FSM states EMPTY (out_valid=0), ONE (main valid, skid empty), FULL (both valid).
  - EMPTY -> ONE on input transfer.
  - ONE -> EMPTY on output transfer with no input.
  - ONE stays ONE on simultaneous input and output transfers; the main register reloads with the new result.
  - ONE -> FULL on input without output; the new result goes to the skid register.
  - FULL -> ONE on output transfer; skid moves to main.
  - in_ready = (state != FULL), registered.
- Ordering: results leave strictly in acceptance order.
- Outputs stable: while out_valid && !out_ready, all outputs hold unchanged.
- Flush: on the next edge the state becomes EMPTY, out_valid=0, in_ready=1. Any input presented in the same cycle as flush is discarded.
- Reset mid-transfer: all entries are lost with no partial output.

Optional Feature:
- Macro: ALU_OVF_TRAP_EN.
- Defined:
  - Signed overflow on ADD/SUB sets extra output port ovf=1.
  - Forces out_reg_write=0 for that entry.
  - result still carries the wrapped sum.
- Undefined: no ovf port; overflow is silently wrapped and reg_write passes through.

Decomposition:
- Shared package alu_pkg holds:
  - The op_code localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_SLL).
  - An ex_entry struct {result, zero, dst_reg, reg_write, bad_op, ovf}.
- One sub-module is natural: alu_core, purely combinational, op_code/op_a/op_b/shamt -> result/zero/bad_op/ovf.
- The top holds the FSM and the two entry registers.

Test Plan:
- ADD: op_code=0010, a=0x00000005, b=0x00000003, out_ready=1 -> next cycle out_valid=1, result=0x00000008, zero=0.
- SUB and SLT:
  - SUB a=7, b=7 -> result=0, zero=1.
  - SLT a=0xFFFFFFFF (-1), b=1 -> result=1.
- SLL/NOR/bad op:
  - SLL b=0x1, shamt=31 -> 0x80000000.
  - NOR a=0, b=0 -> 0xFFFFFFFF.
  - op_code=1010 -> bad_op=1, out_reg_write=0.
- Backpressure:
  - out_ready=0, send 3 back-to-back ops -> in_ready drops after the 2nd is accepted and the 3rd is held.
  - Raise out_ready -> results emerge in order 1, 2, 3 with no loss or duplication.
- Flush/reset:
  - FULL state, assert flush -> next cycle out_valid=0, in_ready=1.
  - Drop rst_n asynchronously mid-cycle -> outputs go to their reset values immediately.
- With ALU_OVF_TRAP_EN: ADD a=0x7FFFFFFF, b=1, reg_write=1 -> result=0x80000000, ovf=1, out_reg_write=0.
